// File: rtl/pc_sequencer.sv
// Program counter owner: fetches words over req/ack and hands them to decode over valid/ready.
// mem_ack in cycle N gives instr_valid in N+1; a fetch is held until ack, a word until instr_ready.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0010
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        rti,
  input  logic        irq,
  output logic        irq_ack,
  output logic        in_isr,
  output logic [15:0] epc,
  input  logic        halt
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic        pend, pend_n;
  logic [15:0] pend_pc, pend_pc_n;
  logic [15:0] instr_n, instr_pc_n, epc_n;
  logic        in_isr_n, irq_ack_n;
  logic        boundary, isr_after;
  logic [15:0] nxt;

  assign mem_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      pend        <= 1'b0;
      pend_pc     <= 16'h0000;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      irq_ack     <= 1'b0;
      in_isr      <= 1'b0;
      epc         <= 16'h0000;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend        <= pend_n;
      pend_pc     <= pend_pc_n;
      mem_req     <= (state_n == REQ);
      instr_valid <= (state_n == ISSUE);
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      irq_ack     <= irq_ack_n;
      in_isr      <= in_isr_n;
      epc         <= epc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend;
    pend_pc_n  = pend_pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    epc_n      = epc;
    in_isr_n   = in_isr;
    irq_ack_n  = 1'b0;

    // redirect wins over rti; rti only releases the handler when it is the one selected
    nxt       = redirect ? redirect_target : (rti ? epc : pc);
    isr_after = in_isr & ~(rti & ~redirect);
    boundary  = (state == IDLE) ||
                ((state == ISSUE) && (instr_ready || redirect || rti));

    if (state == REQ) begin
      if (redirect) begin
        pend_n    = 1'b1;
        pend_pc_n = redirect_target;
      end else if (rti) begin
        pend_n    = 1'b1;
        pend_pc_n = epc;
        in_isr_n  = 1'b0;
      end
      if (mem_ack) begin
        if (pend_n) begin
          // stale word: refetch from the new target without presenting it to decode
          pc_n   = pend_pc_n;
          pend_n = 1'b0;
        end else begin
          instr_n    = mem_rdata;
          instr_pc_n = pc;
          pc_n       = pc + 16'd1;
          state_n    = ISSUE;
        end
      end
    end

    if (boundary) begin
      in_isr_n = isr_after;
      pc_n     = nxt;
      if (irq && !isr_after) begin
        epc_n     = nxt;
        pc_n      = IRQ_VECTOR;
        in_isr_n  = 1'b1;
        irq_ack_n = 1'b1;
      end
      state_n = halt ? IDLE : REQ;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: memory responder with programmable ack delay plus hand-computed checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        rti = 1'b0;
  logic        irq = 1'b0;
  logic        irq_ack;
  logic        in_isr;
  logic [15:0] epc;
  logic        halt = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_delay = 1;
  int mem_cnt = 0;

  logic [15:0] req_a [16];
  logic [15:0] iss_pc_a [16];
  logic [15:0] iss_in_a [16];
  int req_n = 0;
  int iss_n = 0;
  int vcyc = 0;
  int irq_cnt = 0;

  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_valid = 1'b0;
  logic [15:0] p_addr = 16'h0000;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target), .rti(rti), .irq(irq),
    .irq_ack(irq_ack), .in_isr(in_isr), .epc(epc), .halt(halt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: ack arrives ack_delay cycles after a request is first seen; data = addr ^ A5A5
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || mem_ack || !mem_req) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else if (mem_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 16'hA5A5;
      end else begin
        mem_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_addr = 16'h0000;
    end else begin
      if (mem_req && (!p_req || mem_addr != p_addr) && req_n < 16) begin
        req_a[req_n] = mem_addr;
        req_n++;
      end
      if (p_req && mem_req && !p_ack) chk("addr_stable", mem_addr, p_addr);
      if (instr_valid && !p_valid) chk("ack_to_valid", p_ack, 1);
      if (instr_valid) vcyc++;
      if (irq_ack) irq_cnt++;
      if (instr_valid && instr_ready && iss_n < 16) begin
        iss_pc_a[iss_n] = instr_pc;
        iss_in_a[iss_n] = instr;
        iss_n++;
      end
      p_req = mem_req; p_ack = mem_ack; p_valid = instr_valid; p_addr = mem_addr;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 16; i++) begin
      req_a[i] = 16'hxxxx; iss_pc_a[i] = 16'hxxxx; iss_in_a[i] = 16'hxxxx;
    end
    req_n = 0; iss_n = 0; vcyc = 0; irq_cnt = 0;
  endtask

  task automatic go_idle();
    int t;
    t = 0;
    halt = 1'b1;
    step();
    while ((mem_req || instr_valid) && t < 40) begin
      step();
      t++;
    end
    chk("idle_reached", {31'd0, mem_req | instr_valid}, 0);
  endtask

  task automatic idle_redirect(input logic [15:0] tgt, input logic h);
    redirect = 1'b1; redirect_target = tgt; halt = h;
    step();
    redirect = 1'b0;
  endtask

  task automatic fetch_one();
    halt = 1'b0;
    step();
    go_idle();
  endtask

  initial begin
    int t;
    clr();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_irq_ack", irq_ack, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_epc", epc, 16'h0000);
    step();
    reset_n = 1'b1;

    // sequential fetch, ack one cycle after each request, decode always ready
    t = 0;
    while (iss_n < 3 && t < 50) begin step(); t++; end
    go_idle();
    chk("t1_req0", req_a[0], 16'h0000);
    chk("t1_req1", req_a[1], 16'h0001);
    chk("t1_req2", req_a[2], 16'h0002);
    chk("t1_pc0", iss_pc_a[0], 16'h0000);
    chk("t1_pc1", iss_pc_a[1], 16'h0001);
    chk("t1_pc2", iss_pc_a[2], 16'h0002);
    chk("t1_in0", iss_in_a[0], 16'hA5A5);
    chk("t1_in2", iss_in_a[2], 16'hA5A7);
    chk("t1_valid_1cyc", vcyc, iss_n);

    // PC wrap
    clr();
    idle_redirect(16'hFFFF, 1'b1);
    chk("t2_pc_loaded", mem_addr, 16'hFFFF);
    fetch_one();
    chk("t2_req_ffff", req_a[0], 16'hFFFF);
    chk("t2_pc_ffff", iss_pc_a[0], 16'hFFFF);
    chk("t2_wrap_addr", mem_addr, 16'h0000);
    fetch_one();
    chk("t2_req_0000", req_a[1], 16'h0000);

    // redirect while REQ is outstanding with slow memory
    clr();
    ack_delay = 3;
    idle_redirect(16'h0020, 1'b0);
    redirect = 1'b1; redirect_target = 16'h0040; halt = 1'b1;
    step();
    redirect = 1'b0;
    t = 0;
    while (!instr_valid && t < 30) begin
      chk("t3_req_hold", mem_req, 1);
      step();
      t++;
    end
    chk("t3_issue_seen", instr_valid, 1);
    go_idle();
    ack_delay = 1;
    chk("t3_req0", req_a[0], 16'h0020);
    chk("t3_req1", req_a[1], 16'h0040);
    chk("t3_iss_pc", iss_pc_a[0], 16'h0040);
    chk("t3_iss_in", iss_in_a[0], 16'hA5E5);
    chk("t3_iss_n", iss_n, 1);

    // interrupt entry, masked second irq, return
    clr();
    idle_redirect(16'h0005, 1'b1);
    irq = 1'b1; halt = 1'b0;
    step();
    halt = 1'b1;
    chk("t4_irq_ack", irq_ack, 1);
    chk("t4_epc", epc, 16'h0005);
    chk("t4_in_isr", in_isr, 1);
    chk("t4_vec_addr", mem_addr, 16'h0010);
    chk("t4_vec_req", mem_req, 1);
    go_idle();
    fetch_one();
    chk("t4_irq_once", irq_cnt, 1);
    chk("t4_req0", req_a[0], 16'h0010);
    chk("t4_req1", req_a[1], 16'h0011);
    chk("t4_epc_kept", epc, 16'h0005);
    irq = 1'b0;
    rti = 1'b1; halt = 1'b0;
    step();
    rti = 1'b0; halt = 1'b1;
    chk("t4_rti_addr", mem_addr, 16'h0005);
    chk("t4_rti_isr", in_isr, 0);
    chk("t4_rti_req", mem_req, 1);
    go_idle();

    // redirect and irq at the same boundary
    clr();
    redirect = 1'b1; redirect_target = 16'h0100; irq = 1'b1; halt = 1'b0;
    step();
    redirect = 1'b0; irq = 1'b0; halt = 1'b1;
    chk("t5_irq_ack", irq_ack, 1);
    chk("t5_epc", epc, 16'h0100);
    chk("t5_vec_addr", mem_addr, 16'h0010);
    go_idle();
    rti = 1'b1;
    step();
    rti = 1'b0;
    chk("t5_rti_addr", mem_addr, 16'h0100);
    chk("t5_rti_isr", in_isr, 0);

    // halt during a stalled ISSUE, then reset in the middle of a REQ
    clr();
    instr_ready = 1'b0;
    idle_redirect(16'h0030, 1'b0);
    t = 0;
    while (!instr_valid && t < 20) begin step(); t++; end
    halt = 1'b1;
    chk("t6_instr_pc", instr_pc, 16'h0030);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold_valid", instr_valid, 1);
      chk("t6_hold_instr", instr, 16'hA595);
      chk("t6_hold_pc", instr_pc, 16'h0030);
    end
    instr_ready = 1'b1;
    step();
    chk("t6_valid_drop", instr_valid, 0);
    chk("t6_halted_req", mem_req, 0);
    step(3);
    chk("t6_halted_req_later", mem_req, 0);
    ack_delay = 3;
    halt = 1'b0;
    step();
    chk("t6_resume_req", mem_req, 1);
    chk("t6_resume_addr", mem_addr, 16'h0031);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req_async", mem_req, 0);
    chk("t6_rst_addr_async", mem_addr, 16'h0000);
    step();
    reset_n = 1'b1;
    ack_delay = 1;
    step();
    chk("t6_post_rst_addr", mem_addr, 16'h0000);
    chk("t6_post_rst_req", mem_req, 1);
    chk("t6_post_rst_isr", in_isr, 0);
    chk("t6_post_rst_epc", epc, 16'h0000);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 16-bit program counter for the CPU core and sequences instruction fetch.
- Issues fetch requests to instruction memory over a req/ack handshake.
- Presents each fetched word to decode over a valid/ready handshake.
- Selects the next PC from sequential (PC+1), branch/jump redirect, interrupt vector or return-from-interrupt.
- Sits between the instruction memory port and the decode stage.

Parameters:
RESET_VECTOR, 16'h0000, PC loaded on reset
IRQ_VECTOR, 16'h0010, PC loaded on interrupt entry

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
mem_req  out  1  fetch request to instruction memory
mem_addr  out  16  fetch address
mem_ack  in  1  memory has returned mem_rdata this cycle
mem_rdata  in  16  fetched instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  16  fetched instruction
instr_pc  out  16  address of instr
instr_ready  in  1  decode accepts instr
redirect  in  1  one-cycle pulse: branch/jump taken
redirect_target  in  16  new PC when redirect=1
rti  in  1  one-cycle pulse: return from interrupt
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse on interrupt entry
in_isr  out  1  handler active; further irq masked
epc  out  16  saved return PC
halt  in  1  level: suppress new fetches

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_VECTOR, mem_req=0, mem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, irq_ack=0, in_isr=0, epc=0, pend=0.
- All outputs are registered. mem_addr always equals pc.
- States:
  - IDLE: go to REQ when halt=0, else stay in IDLE.
  - REQ: mem_req=1. Leave REQ only on mem_ack.
  - ISSUE: instr_valid=1. Wait for instr_ready.
- REQ rules:
  - mem_req cannot be withdrawn until mem_ack; only reset aborts it.
  - mem_addr is stable while mem_req=1.
  - On mem_ack with pend=0: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1, go to ISSUE.
  - PC increment is modulo 2^16: 16'hFFFF wraps to 16'h0000.
  - redirect or rti while in REQ: set pend=1 and latch the target (redirect_target, or epc for rti). On mem_ack, discard the data, pc<=latched target, pend<=0, go to REQ. No instr_valid is produced for the discarded word.
- Latency: mem_ack in cycle N gives instr_valid=1 in cycle N+1. Best-case throughput is one instruction per 2 cycles (ack in first REQ cycle, ready in first ISSUE cycle).
- ISSUE rules:
  - instr, instr_pc and instr_valid hold stable until instr_ready=1.
  - Handshake completes when instr_valid&instr_ready. Next cycle instr_valid=0.
- Instruction boundary (after ISSUE handshake, or in IDLE):
  - Compute nxt = redirect_target if redirect; else epc if rti (also clears in_isr); else pc.
  - If irq=1 and in_isr=0 (after any rti clear this cycle): epc<=nxt, pc<=IRQ_VECTOR, in_isr<=1, irq_ack=1 for exactly one cycle.
  - Otherwise pc<=nxt.
  - Next state is IDLE if halt=1, else REQ.
- redirect/rti in ISSUE without instr_ready: drop instr_valid next cycle (instruction squashed), pc<=target, go to REQ (IDLE if halt). The irq check applies as at a boundary.
- Simultaneous events:
  - redirect beats rti.
  - redirect/rti beat sequential PC.
  - irq entry is applied after redirect selection, so epc captures the redirect target.
- halt never aborts an outstanding REQ or a valid ISSUE. It only blocks entry to REQ.
- irq is sampled only at boundaries. irq while in_isr=1 is ignored (no nesting).
- rti while in_isr=0 still loads epc into pc.
- reset_n low mid-REQ drops mem_req immediately (asynchronously).

Test Plan:
- Reset release, mem_ack one cycle after each req, instr_ready=1 -> mem_addr sequence 0000,0001,0002; instr_pc matches; instr_valid high 1 cycle each, one cycle after ack.
- pc=16'hFFFF fetched -> next mem_addr=16'h0000.
- redirect=1, target=16'h0040 while in REQ with ack delayed 3 cycles -> that word is not issued; next mem_addr=0040; mem_req stays high until ack.
- irq=1 at boundary with pc=0005 -> irq_ack pulse, epc=0005, in_isr=1, next mem_addr=0010. Second irq during handler is ignored. rti -> next mem_addr=0005, in_isr=0.
- redirect to 0x0100 and irq in the same boundary cycle -> epc=0100, next mem_addr=0010.
- halt=1 during ISSUE with instr_ready low for 4 cycles -> instr stable; after handshake, mem_req stays 0 until halt=0. Assert reset_n=0 mid-REQ -> mem_req=0 at once; after release, mem_addr=0000.
